// File: rtl/lbm_stream_writer_if.sv
// Collider-result input stream and lattice-memory write port of the D2Q9 streaming stage.
// master: the stream writer itself; slave: the collider/memory side driving it.
interface lbm_stream_writer_if #(
  parameter int ADDR_W = 12
);
  localparam int DATA_W = 16;

  logic                     in_valid;
  logic                     in_ready;
  logic [9*DATA_W-1:0]      f_in;
  logic                     mem_we;
  logic                     mem_ready;
  logic [3:0]               mem_dir;
  logic [ADDR_W-1:0]        mem_addr;
  logic signed [DATA_W-1:0] mem_wdata;
  logic                     frame_done;

  modport master (
    input  in_valid, f_in, mem_ready,
    output in_ready, mem_we, mem_dir, mem_addr, mem_wdata, frame_done
  );

  modport slave (
    output in_valid, f_in, mem_ready,
    input  in_ready, mem_we, mem_dir, mem_addr, mem_wdata, frame_done
  );
endinterface

// File: rtl/lbm_stream_writer.sv
// D2Q9 streaming stage: latches one cell's nine distributions and writes each one
// to its periodic-wrapped neighbour cell in its own direction plane.
module lbm_stream_writer #(
  parameter int NX     = 64,
  parameter int NY     = 64,
  parameter int ADDR_W = 12
) (
  input  logic              clk,
  input  logic              rst,
  lbm_stream_writer_if.master bus
);
  localparam int DATA_W = 16;
  localparam int XW     = $clog2(NX);
  localparam int YW     = $clog2(NY);
  localparam logic [XW-1:0] X_ONE = 1;
  localparam logic [YW-1:0] Y_ONE = 1;
  localparam logic [XW-1:0] X_MAX = '1;
  localparam logic [YW-1:0] Y_MAX = '1;

  typedef enum logic {IDLE, WRITE} state_t;

  state_t                   state;
  logic [XW-1:0]            x;
  logic [YW-1:0]            y;
  logic [3:0]               dir;
  logic [8:0][DATA_W-1:0]   hold;
  logic [3:0]               dir_nxt;

  assign dir_nxt = dir + 4'd1;

  // Power-of-two lattice: +/-1 in the native counter width is the periodic wrap.
  function automatic logic [ADDR_W-1:0] dest(input logic [XW-1:0] cx,
                                             input logic [YW-1:0] cy,
                                             input logic [3:0]    d);
    logic [XW-1:0] xd;
    logic [YW-1:0] yd;
    xd = cx;
    yd = cy;
    case (d)
      4'd1: yd = cy + Y_ONE;
      4'd2: begin xd = cx + X_ONE; yd = cy + Y_ONE; end
      4'd3: xd = cx + X_ONE;
      4'd4: begin xd = cx + X_ONE; yd = cy - Y_ONE; end
      4'd5: yd = cy - Y_ONE;
      4'd6: begin xd = cx - X_ONE; yd = cy - Y_ONE; end
      4'd7: xd = cx - X_ONE;
      4'd8: begin xd = cx - X_ONE; yd = cy + Y_ONE; end
      default: ;
    endcase
    return {yd, xd};
  endfunction

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state          <= IDLE;
      x              <= '0;
      y              <= '0;
      dir            <= '0;
      hold           <= '0;
      bus.in_ready   <= 1'b1;
      bus.mem_we     <= 1'b0;
      bus.mem_dir    <= '0;
      bus.mem_addr   <= '0;
      bus.mem_wdata  <= '0;
      bus.frame_done <= 1'b0;
    end else begin
      bus.frame_done <= 1'b0;
      case (state)
        IDLE: begin
          if (bus.in_valid) begin
            hold          <= bus.f_in;
            dir           <= 4'd0;
            bus.mem_dir   <= 4'd0;
            bus.mem_addr  <= dest(x, y, 4'd0);
            bus.mem_wdata <= bus.f_in[DATA_W-1:0];
            bus.mem_we    <= 1'b1;
            bus.in_ready  <= 1'b0;
            state         <= WRITE;
          end
        end
        WRITE: begin
          // Outputs only move on an accepted write, so backpressure holds them.
          if (bus.mem_ready) begin
            if (dir < 4'd8) begin
              dir           <= dir_nxt;
              bus.mem_dir   <= dir_nxt;
              bus.mem_addr  <= dest(x, y, dir_nxt);
              bus.mem_wdata <= hold[dir_nxt];
            end else begin
              bus.mem_we   <= 1'b0;
              bus.in_ready <= 1'b1;
              state        <= IDLE;
              x            <= x + X_ONE;
              if (x == X_MAX) begin
                y <= y + Y_ONE;
                if (y == Y_MAX) bus.frame_done <= 1'b1;
              end
            end
          end
        end
        default: state <= IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_lbm_stream_writer.sv
// Directed scoreboard bench for lbm_stream_writer on a 4x4 lattice.
module tb_lbm_stream_writer;
  localparam int NX = 4;
  localparam int NY = 4;
  localparam int AW = 4;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  lbm_stream_writer_if #(.ADDR_W(AW)) bus ();

  lbm_stream_writer #(.NX(NX), .NY(NY), .ADDR_W(AW)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  int checks = 0;
  int errors = 0;
  int cyc = 0;
  int rdy_count = 0;
  int fd_count = 0;
  int fd_cycle = -1;
  int last_d8_cyc = -1;
  int cell_start = 0;
  int mx = 0;
  int my = 0;
  logic [23:0] exp_q[$];
  int dx_t[9] = '{0, 0, 1, 1, 1, 0, -1, -1, -1};
  int dy_t[9] = '{0, 1, 1, 0, -1, -1, -1, 0, 1};

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h required %0h", tag, obs, exp);
    end
  endtask

  // One clock: sample at negedge, then return 1 time unit after the next posedge.
  task automatic tick();
    logic [23:0] obs;
    logic [23:0] e;
    @(negedge clk);
    cyc++;
    if (bus.in_ready) rdy_count++;
    if (bus.frame_done) begin
      fd_count++;
      fd_cycle = cyc;
    end
    if (bus.mem_we && bus.mem_ready) begin
      obs = {bus.mem_dir, bus.mem_addr, bus.mem_wdata};
      if (exp_q.size() == 0) begin
        chk("spurious_write_queue", exp_q.size(), 1);
      end else begin
        e = exp_q.pop_front();
        chk("write_dir_addr_data", obs, e);
        if (bus.mem_dir == 4'd8) last_d8_cyc = cyc;
      end
    end
    @(posedge clk);
    #1;
  endtask

  task automatic push_cell(input int cx, input int cy, input logic [15:0] base);
    int xd;
    int yd;
    for (int i = 0; i < 9; i++) begin
      xd = (cx + dx_t[i] + NX) % NX;
      yd = (cy + dy_t[i] + NY) % NY;
      exp_q.push_back({4'(i), 4'(yd * NX + xd), 16'(base + 16'(i))});
    end
  endtask

  task automatic advance_pos();
    mx = (mx + 1) % NX;
    if (mx == 0) my = (my + 1) % NY;
  endtask

  task automatic set_fin(input logic [15:0] base);
    for (int i = 0; i < 9; i++) bus.f_in[16*i +: 16] = 16'(base + 16'(i));
  endtask

  task automatic send_cell(input logic [15:0] base);
    int n;
    n = 0;
    while (!bus.in_ready && n < 50) begin
      tick();
      n++;
    end
    if (!bus.in_ready) chk("in_ready_wait", bus.in_ready, 1);
    push_cell(mx, my, base);
    set_fin(base);
    bus.in_valid = 1'b1;
    tick();
    bus.in_valid = 1'b0;
    cell_start = cyc;
    chk("accept_mem_we", bus.mem_we, 1);
    chk("accept_in_ready", bus.in_ready, 0);
    advance_pos();
  endtask

  task automatic drain();
    int n;
    n = 0;
    while (exp_q.size() != 0 && n < 100) begin
      tick();
      n++;
    end
    chk("drain_queue_empty", exp_q.size(), 0);
  endtask

  initial begin
    logic [23:0] hold_v;
    int rdy0;
    int fd0;
    int n;

    rst = 1'b0;
    bus.in_valid = 1'b0;
    bus.mem_ready = 1'b1;
    bus.f_in = '0;
    tick();
    tick();

    chk("reset_in_ready", bus.in_ready, 1);
    chk("reset_mem_we", bus.mem_we, 0);
    chk("reset_mem_dir", bus.mem_dir, 0);
    chk("reset_mem_addr", bus.mem_addr, 0);
    chk("reset_mem_wdata", bus.mem_wdata, 0);
    chk("reset_frame_done", bus.frame_done, 0);
    rst = 1'b1;
    tick();

    // Five dummy cells, then the interior cell (1,1)
    for (int c = 0; c < 5; c++) begin
      send_cell(16'h1000 + 16'(c * 16));
      drain();
    end
    send_cell(16'h0100);
    drain();
    chk("cell_time_nominal", cyc - cell_start + 1, 10);

    // Rest of the frame
    for (int c = 6; c < 15; c++) begin
      send_cell(16'h2000 + 16'(c * 16));
      drain();
    end
    chk("frame_done_early", fd_count, 0);
    send_cell(16'h2F00);
    drain();
    tick();
    chk("frame_done_count", fd_count, 1);
    chk("frame_done_timing", fd_cycle, last_d8_cyc + 1);
    tick();
    chk("frame_done_single", fd_count, 1);

    // 17th cell wraps to the corner (0,0)
    chk("model_at_origin", mx + my, 0);
    send_cell(16'h0100);
    drain();

    // Backpressure on cell (1,0) while dir 4 is presented
    send_cell(16'h0700);
    n = 0;
    while (!(bus.mem_we && bus.mem_dir == 4'd4) && n < 20) begin
      tick();
      n++;
    end
    chk("bp_reach_dir4", bus.mem_dir, 4);
    hold_v = {bus.mem_dir, bus.mem_addr, bus.mem_wdata};
    bus.mem_ready = 1'b0;
    repeat (3) begin
      tick();
      chk("bp_outputs_held", {bus.mem_dir, bus.mem_addr, bus.mem_wdata}, hold_v);
      chk("bp_mem_we_held", bus.mem_we, 1);
    end
    bus.mem_ready = 1'b1;
    drain();
    chk("bp_cell_time", cyc - cell_start + 1, 13);

    // Input hold-off: in_valid stays high and f_in churns during WRITE
    rdy0 = rdy_count;
    for (int c = 0; c < 2; c++) begin
      n = 0;
      while (!bus.in_ready && n < 50) begin
        tick();
        n++;
      end
      push_cell(mx, my, 16'h0300 + 16'(c * 16));
      set_fin(16'h0300 + 16'(c * 16));
      bus.in_valid = 1'b1;
      tick();
      advance_pos();
      repeat (9) begin
        for (int i = 0; i < 9; i++) bus.f_in[16*i +: 16] = 16'($urandom());
        tick();
      end
    end
    bus.in_valid = 1'b0;
    chk("holdoff_ready_duty", rdy_count - rdy0, 2);
    chk("holdoff_queue_empty", exp_q.size(), 0);

    // Reset in the middle of cell 2
    rst = 1'b0;
    tick();
    rst = 1'b1;
    mx = 0;
    my = 0;
    send_cell(16'h4000);
    drain();
    send_cell(16'h4010);
    drain();
    send_cell(16'h4020);
    n = 0;
    while (bus.mem_dir != 4'd3 && n < 20) begin
      tick();
      n++;
    end
    chk("rst_reach_dir3", bus.mem_dir, 3);
    fd0 = fd_count;
    rst = 1'b0;
    #1;
    chk("midrst_mem_we", bus.mem_we, 0);
    chk("midrst_in_ready", bus.in_ready, 1);
    chk("midrst_mem_dir", bus.mem_dir, 0);
    chk("midrst_mem_addr", bus.mem_addr, 0);
    chk("midrst_mem_wdata", bus.mem_wdata, 0);
    chk("midrst_frame_done", bus.frame_done, 0);
    exp_q.delete();
    tick();
    tick();
    rst = 1'b1;
    mx = 0;
    my = 0;
    send_cell(16'h0500);
    drain();
    tick();
    chk("midrst_no_frame_done", fd_count, fd0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
